// File: rtl/sha256_pad_pkg.sv
// Shared types and constants for the SHA-256 message padder.
// FSM state encoding plus the padding byte layout constants.
package sha256_pad_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        PAD,
        ARM,
        SEND,
        DONE
    } pad_state_t;

    localparam logic [7:0] PAD_BYTE       = 8'h80;
    localparam int         BLOCK_WORDS    = 16;
    localparam int         LEN_FIELD_BYTE = 56;

endpackage

// File: rtl/sha256_blk_buf.sv
// 64-byte block buffer: byte-lane write of up to IN_BYTES bytes at any byte address,
// combinational big-endian 32-bit word read.
module sha256_blk_buf
    import sha256_pad_pkg::*;
#(
    parameter int IN_BYTES = 4
) (
    input  logic                             i_clk,
    input  logic                             i_we,
    input  logic [5:0]                       i_addr,
    input  logic [8*IN_BYTES-1:0]            i_dat,
    input  logic [$clog2(IN_BYTES+1)-1:0]    i_nb,
    input  logic [$clog2(BLOCK_WORDS)-1:0]   i_ridx,
    output logic [31:0]                      o_rdat
);

    logic [7:0] r_mem [64];

    // Lane 0 is the most significant byte of i_dat and lands at i_addr.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int k = 0; k < IN_BYTES; k++) begin
                if (k < int'(i_nb)) begin
                    r_mem[i_addr + 6'(k)] <= i_dat[8*(IN_BYTES-1-k) +: 8];
                end
            end
        end
    end

    assign o_rdat = {r_mem[{i_ridx, 2'd0}], r_mem[{i_ridx, 2'd1}],
                     r_mem[{i_ridx, 2'd2}], r_mem[{i_ridx, 2'd3}]};

endmodule

// File: rtl/sha256_msg_padder.sv
// Streams a byte message into FIPS 180-4 padded 16-word blocks for the SHA-256 core.
// Optional block counter on o_blk_count is built only when SHA_PAD_BLKCNT_EN is defined.
module sha256_msg_padder
    import sha256_pad_pkg::*;
#(
    parameter int IN_BYTES = 4,
    parameter int LEN_W    = 32
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_in_valid,
    output logic                          o_in_ready,
    input  logic [8*IN_BYTES-1:0]         i_in_data,
    input  logic                          i_in_last,
    input  logic [$clog2(IN_BYTES+1)-1:0] i_in_nbytes,
    input  logic                          i_core_busy,
    output logic [31:0]                   o_core_data,
    output logic                          o_core_write_enable,
    output logic                          o_core_first_block,
    output logic                          o_core_last_block,
    output logic                          o_msg_done,
    output logic                          o_len_err,
    output logic [15:0]                   o_blk_count
);

    localparam int NBW = $clog2(IN_BYTES+1);
    localparam int CW  = LEN_W + 1;

    pad_state_t         r_state;
    logic [5:0]         r_bp;
    logic [LEN_W-1:0]   r_cnt;
    logic               r_first, r_pad_pending, r_final, r_pad80, r_lenmode;
    logic [3:0]         r_idx;
    logic               r_in_ready, r_we, r_first_o, r_last_o, r_done, r_len_err;
    logic [31:0]        r_data;

    logic               w_accept, w_lenmode, w_we;
    logic [NBW-1:0]     w_nb, w_pad_nb, w_wr_nb;
    logic [6:0]         w_bp_sum, w_pad_sum, w_room;
    logic [CW-1:0]      w_cnt_sum;
    logic [63:0]        w_len_bits;
    logic [8*IN_BYTES-1:0] w_pad_dat, w_wr_dat;
    logic [31:0]        w_rd_word;

    assign w_accept   = i_in_valid && r_in_ready && (r_state == FILL);
    assign w_nb       = i_in_last ? i_in_nbytes : NBW'(IN_BYTES);
    assign w_bp_sum   = {1'b0, r_bp} + 7'(w_nb);
    assign w_cnt_sum  = {1'b0, r_cnt} + CW'(w_nb);
    assign w_len_bits = 64'(r_cnt) << 3;

    // Length-field mode is decided when 0x80 lands: it must end at or before byte 56.
    assign w_lenmode  = r_pad80 ? r_lenmode : (r_bp <= 6'(LEN_FIELD_BYTE-1));
    assign w_room     = 7'd64 - {1'b0, r_bp};
    assign w_pad_nb   = (w_room >= 7'(IN_BYTES)) ? NBW'(IN_BYTES) : NBW'(w_room);
    assign w_pad_sum  = {1'b0, r_bp} + 7'(w_pad_nb);

    always_comb begin
        w_pad_dat = '0;
        for (int k = 0; k < IN_BYTES; k++) begin
            if (k == 0 && !r_pad80) begin
                w_pad_dat[8*(IN_BYTES-1-k) +: 8] = PAD_BYTE;
            end else if (w_lenmode && (({1'b0, r_bp} + 7'(k)) >= 7'(LEN_FIELD_BYTE))) begin
                w_pad_dat[8*(IN_BYTES-1-k) +: 8] =
                    w_len_bits[{3'd7 - (r_bp[2:0] + 3'(k)), 3'b000} +: 8];
            end
        end
    end

    assign w_we     = w_accept || (r_state == PAD);
    assign w_wr_dat = (r_state == PAD) ? w_pad_dat : i_in_data;
    assign w_wr_nb  = (r_state == PAD) ? w_pad_nb  : w_nb;

    sha256_blk_buf #(.IN_BYTES(IN_BYTES)) u_buf (
        .i_clk  (i_clk),
        .i_we   (w_we),
        .i_addr (r_bp),
        .i_dat  (w_wr_dat),
        .i_nb   (w_wr_nb),
        .i_ridx (r_idx),
        .o_rdat (w_rd_word)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_bp          <= '0;
            r_cnt         <= '0;
            r_first       <= 1'b0;
            r_pad_pending <= 1'b0;
            r_final       <= 1'b0;
            r_pad80       <= 1'b0;
            r_lenmode     <= 1'b0;
            r_idx         <= '0;
            r_in_ready    <= 1'b0;
            r_we          <= 1'b0;
            r_first_o     <= 1'b0;
            r_last_o      <= 1'b0;
            r_done        <= 1'b0;
            r_len_err     <= 1'b0;
            r_data        <= '0;
        end else begin
            r_we       <= 1'b0;
            r_first_o  <= 1'b0;
            r_last_o   <= 1'b0;
            r_done     <= 1'b0;
            r_in_ready <= 1'b0;
            r_data     <= '0;
            case (r_state)
                IDLE: begin
                    r_first       <= 1'b1;
                    r_bp          <= '0;
                    r_cnt         <= '0;
                    r_pad80       <= 1'b0;
                    r_pad_pending <= 1'b0;
                    r_final       <= 1'b0;
                    r_in_ready    <= 1'b1;
                    r_state       <= FILL;
                end
                FILL: begin
                    if (w_accept) begin
                        r_cnt <= w_cnt_sum[LEN_W-1:0];
                        if (w_cnt_sum[LEN_W]) r_len_err <= 1'b1;
                        if (w_bp_sum[6]) begin
                            // A full final beat still needs a separate padding block.
                            r_bp          <= '0;
                            r_pad_pending <= i_in_last;
                            r_pad80       <= 1'b0;
                            r_final       <= 1'b0;
                            r_state       <= ARM;
                        end else if (i_in_last) begin
                            r_bp    <= w_bp_sum[5:0];
                            r_pad80 <= 1'b0;
                            r_state <= PAD;
                        end else begin
                            r_bp       <= w_bp_sum[5:0];
                            r_in_ready <= 1'b1;
                        end
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                PAD: begin
                    r_pad80 <= 1'b1;
                    if (w_pad_sum[6]) begin
                        r_bp          <= '0;
                        r_final       <= w_lenmode;
                        r_pad_pending <= !w_lenmode;
                        r_lenmode     <= 1'b1;
                        r_state       <= ARM;
                    end else begin
                        r_bp      <= w_pad_sum[5:0];
                        r_lenmode <= w_lenmode;
                    end
                end
                ARM: begin
                    if (!i_core_busy) begin
                        r_first_o <= r_first;
                        r_idx     <= '0;
                        r_state   <= SEND;
                    end
                end
                SEND: begin
                    r_we   <= 1'b1;
                    r_data <= w_rd_word;
                    r_idx  <= r_idx + 4'd1;
                    if (r_idx == '0) begin
                        r_first_o <= r_first;
                        r_last_o  <= r_final;
                        r_first   <= 1'b0;
                    end
                    if (r_idx == 4'(BLOCK_WORDS-1)) begin
                        if (r_final) begin
                            r_state <= DONE;
                        end else if (r_pad_pending) begin
                            r_pad_pending <= 1'b0;
                            r_state       <= PAD;
                        end else begin
                            r_in_ready <= 1'b1;
                            r_state    <= FILL;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef SHA_PAD_BLKCNT_EN
    logic [15:0] r_blk_count;
    logic        w_blk_done;
    assign w_blk_done = (r_state == SEND) && (r_idx == 4'(BLOCK_WORDS-1));
    always_ff @(posedge i_clk) begin
        if (i_reset)         r_blk_count <= '0;
        else if (w_blk_done) r_blk_count <= r_blk_count + 16'd1;
    end
    assign o_blk_count = r_blk_count;
`else
    assign o_blk_count = '0;
`endif

    assign o_in_ready          = r_in_ready;
    assign o_core_data         = r_data;
    assign o_core_write_enable = r_we;
    assign o_core_first_block  = r_first_o;
    assign o_core_last_block   = r_last_o;
    assign o_msg_done          = r_done;
    assign o_len_err           = r_len_err;

endmodule

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
Streaming front end for the SHA-256 core (`top`). It accepts an arbitrary-length byte message on a valid/ready stream and applies FIPS 180-4 padding: 0x80, zero fill, and a 64-bit big-endian bit length. It emits 16-word blocks with the core's write_enable/first_block/last_block protocol. This replaces hand-built padded stimulus and lets a host feed raw messages.

Parameters:
IN_BYTES, 4, bytes per input beat; legal values 1, 2, 4; byte 0 is in_data[8*IN_BYTES-1 -: 8], big-endian.
LEN_W, 32, width of the internal message byte counter; the maximum message length is 2^LEN_W-1 bytes.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  padder accepts the beat this cycle
in_data  in  8*IN_BYTES  message bytes, MSB-first
in_last  in  1  final beat of the message
in_nbytes  in  $clog2(IN_BYTES+1)  valid byte count of the beat; sampled only when in_last=1 (0..IN_BYTES); other beats are full
core_busy  in  1  busy output of the SHA-256 core
core_data  out  32  word to the core
core_write_enable  out  1  core_data valid
core_first_block  out  1  first-block flag to the core
core_last_block  out  1  last-block flag to the core
msg_done  out  1  one-cycle pulse after the final word is sent
len_err  out  1  sticky flag: byte counter overflowed
blk_count  out  16  blocks sent since reset (feature-dependent)

Behaviour:
- Reset: state IDLE. All outputs 0, except in_ready=0. Buffer contents are don't-care. len_err and blk_count are cleared.
- Internals:
  - 16x32 block buffer.
  - 6-bit byte pointer bp (0..63).
  - LEN_W byte counter.
  - first flag.
  - 4-bit send index.
- IDLE:
  - The first flag is set.
  - The FSM moves to FILL next cycle.
- FILL:
  - in_ready=1.
  - Each accepted beat writes its bytes at bp (IN_BYTES or in_nbytes), advances bp, and adds to the counter.
  - Beats never straddle a block boundary, because 64 is a multiple of IN_BYTES.
  - bp wraps to 0 on a full block, and the FSM goes to ARM with pad_pending=0 (more message data follows).
  - A beat with in_last goes to PAD; a full final beat goes to ARM first and then to PAD.
- PAD (in_ready=0):
  - Writes 0x80 at bp, then zeros.
  - If bp after 0x80 is at most 56: zero to byte 55, put the length (counter<<3, zero-extended to 64 bits) in bytes 56..63, and mark final.
  - Otherwise: zero to byte 63, send the block, and return to PAD at bp=0 with 0x80 already placed (zero fill plus length only).
  - PAD may take multiple cycles. One word per cycle is allowed.
- ARM (1 cycle):
  - Waits here while core_busy=1.
  - When core_busy=0, asserts core_first_block if the first flag is set, then moves to SEND.
- SEND (16 cycles, uninterrupted):
  - core_write_enable=1 and core_data=buf[idx].
  - core_first_block stays high during word 0 of the first block.
  - core_last_block is high during word 0 of the final block only.
  - The first flag clears after word 0.
  - After word 15: blk_count increments; the FSM goes to FILL, PAD, or DONE.
- DONE: msg_done pulses for 1 cycle, then the FSM returns to IDLE.
- Length boundaries:
  - 0 bytes: 1 block.
  - 55 bytes: 1 block.
  - 56 to 63 bytes: 2 blocks.
  - 64 bytes: 2 blocks (data block, then padding block).
- Counter overflow sets len_err (sticky). The length field uses the wrapped count.
- in_valid while in_ready=0 is held by the source; nothing is lost.
- in_last with in_nbytes=0 on a non-empty message means the message ended on the previous beat.
- Reset mid-SEND aborts immediately. core_write_enable drops in the next cycle, and the core must also be reset.

Optional Feature:
SHA_PAD_BLKCNT_EN
- Defined: blk_count is a 16-bit wrapping counter of blocks sent, cleared by reset.
- Undefined: blk_count is tied to 0 and no counter flops are built.

Decomposition:
- Package sha256_pad_pkg holds:
  - the FSM state enum (IDLE, FILL, PAD, ARM, SEND, DONE);
  - the constants PAD_BYTE=8'h80, BLOCK_WORDS=16, LEN_FIELD_BYTE=56.
- One sub-module, sha256_blk_buf: 64-byte buffer with a byte-lane write port (IN_BYTES wide) and a 32-bit word read port.

Test Plan:
- 56 ASCII '0' bytes, IN_BYTES=4 -> expected words:
  - Block 1: 0x30303030 x14, then 0x80000000, then 0x00000000. first_block is high the cycle before and during word 0.
  - Block 2: 0x00000000 x15, then 0x000001c0. last_block is high on word 0.
  - The core digest is bd03ac14...857ffc18.
- "abc", IN_BYTES=1 -> one block: 0x61626380, zeros, last word 0x00000018. first_block and last_block are both high on word 0.
- Empty message (in_last, in_nbytes=0) -> one block: 0x80000000, then 15 zero words.
- 55-byte and 64-byte messages -> 1 block (length 0x1b8) and 2 blocks (second block 0x80000000 ... 0x00000200) respectively.
- core_busy held high for 49 cycles between blocks -> the FSM stays in ARM, no write_enable is issued, and in_ready=0.
- Reset asserted at SEND word 7 -> the next cycle shows all outputs 0; then a new "abc" message produces the correct block.
